core_mem_port: RTL and testbench

- Per-core initiator for the shared-memory bank arbiters.
- Accepts load/store requests from a core pipeline into a small FIFO and issues them one at a time on the core's slice of the shared-memory interface (core_val, read, write, 12-bit address, 8-bit data).
- Waits for the arbiter's one-cycle finish pulse, captures read data and returns a response to the core.
- Sixteen instances, one per core, sit between the cores and the bank arbiters.

---
 rtl/shared_mem_pkg.sv | 24 ++
 rtl/core_mem_port_if.sv | 44 ++++
 rtl/core_mem_port_fifo.sv | 52 +++++
 rtl/core_mem_port.sv | 152 +++++++++++++++
 tb/tb_core_mem_port.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/shared_mem_pkg.sv
// Shared definitions for the per-core shared-memory initiators: field widths,
// the port FSM state type and the packed request record held in the FIFO.
package shared_mem_pkg;
    localparam int ADDR_W     = 12;
    localparam int DATA_W     = 8;
    localparam int BANK_W     = 4;
    localparam int OFFSET_W   = 8;
    localparam int NUM_CORES  = 16;
    localparam int OFFSET_LSB = 0;
    localparam int BANK_LSB   = OFFSET_LSB + OFFSET_W;
    localparam int REQ_W      = 1 + ADDR_W + DATA_W;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} port_state_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

    function automatic logic [BANK_W-1:0] bank_of(input logic [ADDR_W-1:0] addr);
        return addr[BANK_LSB +: BANK_W];
    endfunction
endpackage

// File: rtl/core_mem_port_if.sv
// Core-side request/response channel and the core's slice of the shared-memory
// bus. Master is the side that starts transactions on each channel.
interface core_req_if;
    import shared_mem_pkg::*;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_we;
    logic              resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_we, resp_err
    );
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_we, resp_err
    );
endinterface

interface mem_bus_if;
    import shared_mem_pkg::*;
    logic              mem_val;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_finish;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_val, mem_read, mem_write, mem_addr, mem_wdata,
        input  mem_finish, mem_rdata
    );
    modport slave (
        input  mem_val, mem_read, mem_write, mem_addr, mem_wdata,
        output mem_finish, mem_rdata
    );
endinterface

// File: rtl/core_mem_port_fifo.sv
// Small synchronous request FIFO. Full/empty come from the registered count, so
// a pop never frees a slot for a push in the same cycle.
module req_fifo #(
    parameter int WIDTH = 21,
    parameter int DEPTH = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_rdata = r_mem[r_rd_ptr];

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clock) begin
        if (w_push) r_mem[r_wr_ptr] <= i_wdata;
    end
endmodule

// File: rtl/core_mem_port.sv
// Per-core initiator: queues core requests, issues one at a time on this core's
// slice of the shared-memory bus, and returns the result (or a timeout error).
module core_mem_port
    import shared_mem_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int TIMEOUT    = 64
) (
    input  logic        clock,
    input  logic        reset,
    core_req_if.slave   core,
    mem_bus_if.master   mem,
    output logic        busy
);
    localparam int CNT_W = $clog2(TIMEOUT);

    port_state_t       r_state, w_state_next;
    logic [CNT_W-1:0]  r_cnt, w_cnt_next;
    logic              r_mem_val, w_mem_val_next;
    logic              r_mem_read, w_mem_read_next;
    logic              r_mem_write, w_mem_write_next;
    logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_next;
    logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata_next;
    logic              r_resp_valid, w_resp_valid_next;
    logic [DATA_W-1:0] r_resp_rdata, w_resp_rdata_next;
    logic              r_resp_we, w_resp_we_next;
    logic              r_resp_err, w_resp_err_next;

    mem_req_t          w_push_req;
    mem_req_t          w_head;
    logic [REQ_W-1:0]  w_head_bits;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic              w_pop;

    assign w_push_req = '{we: core.req_we, addr: core.req_addr, wdata: core.req_wdata};
    assign w_head     = mem_req_t'(w_head_bits);

    req_fifo #(.WIDTH(REQ_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .i_push  (core.req_valid),
        .i_wdata (w_push_req),
        .i_pop   (w_pop),
        .o_rdata (w_head_bits),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    always_comb begin
        w_state_next      = r_state;
        w_cnt_next        = r_cnt;
        w_mem_val_next    = r_mem_val;
        w_mem_read_next   = r_mem_read;
        w_mem_write_next  = r_mem_write;
        w_mem_addr_next   = r_mem_addr;
        w_mem_wdata_next  = r_mem_wdata;
        w_resp_valid_next = r_resp_valid;
        w_resp_rdata_next = r_resp_rdata;
        w_resp_we_next    = r_resp_we;
        w_resp_err_next   = r_resp_err;
        w_pop             = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop            = 1'b1;
                    w_state_next     = BUSY;
                    w_cnt_next       = '0;
                    w_mem_val_next   = 1'b1;
                    w_mem_read_next  = !w_head.we;
                    w_mem_write_next = w_head.we;
                    w_mem_addr_next  = w_head.addr;
                    w_mem_wdata_next = w_head.wdata;
                end
            end
            BUSY: begin
                // Finish is checked first so it beats a coincident timeout.
                if (mem.mem_finish) begin
                    w_state_next      = RESP;
                    w_mem_val_next    = 1'b0;
                    w_mem_read_next   = 1'b0;
                    w_mem_write_next  = 1'b0;
                    w_resp_valid_next = 1'b1;
                    w_resp_rdata_next = r_mem_write ? '0 : mem.mem_rdata;
                    w_resp_we_next    = r_mem_write;
                    w_resp_err_next   = 1'b0;
                end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                    w_state_next      = RESP;
                    w_mem_val_next    = 1'b0;
                    w_mem_read_next   = 1'b0;
                    w_mem_write_next  = 1'b0;
                    w_mem_addr_next   = '0;
                    w_mem_wdata_next  = '0;
                    w_resp_valid_next = 1'b1;
                    w_resp_rdata_next = '0;
                    w_resp_we_next    = r_mem_write;
                    w_resp_err_next   = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            RESP: begin
                if (core.resp_ready) begin
                    w_state_next      = IDLE;
                    w_resp_valid_next = 1'b0;
                    w_resp_err_next   = 1'b0;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_mem_val    <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_we    <= 1'b0;
            r_resp_err   <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_cnt        <= w_cnt_next;
            r_mem_val    <= w_mem_val_next;
            r_mem_read   <= w_mem_read_next;
            r_mem_write  <= w_mem_write_next;
            r_mem_addr   <= w_mem_addr_next;
            r_mem_wdata  <= w_mem_wdata_next;
            r_resp_valid <= w_resp_valid_next;
            r_resp_rdata <= w_resp_rdata_next;
            r_resp_we    <= w_resp_we_next;
            r_resp_err   <= w_resp_err_next;
        end
    end

    assign core.req_ready  = !w_fifo_full;
    assign core.resp_valid = r_resp_valid;
    assign core.resp_rdata = r_resp_rdata;
    assign core.resp_we    = r_resp_we;
    assign core.resp_err   = r_resp_err;
    assign mem.mem_val     = r_mem_val;
    assign mem.mem_read    = r_mem_read;
    assign mem.mem_write   = r_mem_write;
    assign mem.mem_addr    = r_mem_addr;
    assign mem.mem_wdata   = r_mem_wdata;
    assign busy            = !w_fifo_empty || (r_state != IDLE);
endmodule

// File: tb/tb_core_mem_port.sv
// Directed scenarios plus randomized traffic for core_mem_port, checked every
// cycle against a transaction-level model (request queue, one outstanding slot).
module tb_core_mem_port;
    import shared_mem_pkg::*;

    localparam int DEPTH = 2;
    localparam int TMO   = 64;

    typedef struct {
        logic        we;
        logic [11:0] addr;
        logic [7:0]  wdata;
    } tb_req_t;

    logic clock = 1'b0;
    logic reset;
    logic busy;

    core_req_if core ();
    mem_bus_if  mem ();

    core_mem_port #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
        .clock (clock),
        .reset (reset),
        .core  (core),
        .mem   (mem),
        .busy  (busy)
    );

    always #5 clock = ~clock;

    // stimulus values applied before the next rising edge
    logic        d_reset, d_valid, d_we, d_resp_ready, d_finish;
    logic [11:0] d_addr;
    logic [7:0]  d_wdata, d_rdata;

    // reference model
    tb_req_t     mq[$];
    logic [11:0] issued_addr[$];
    bit          have_cur, resp_pending, after_reset;
    tb_req_t     cur;
    int          cur_cycles;
    logic [7:0]  exp_rdata;
    logic        exp_we, exp_err;
    logic [11:0] resp_addr;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    endtask

    task automatic compare();
        chk("req_ready", core.req_ready, mq.size() < DEPTH);
        chk("busy", busy, (mq.size() != 0) || have_cur || resp_pending);
        chk("mem_val", mem.mem_val, have_cur);
        if (have_cur) begin
            chk("mem_addr", mem.mem_addr, cur.addr);
            chk("mem_wdata", mem.mem_wdata, cur.wdata);
            chk("mem_read", mem.mem_read, !cur.we);
            chk("mem_write", mem.mem_write, cur.we);
        end else begin
            chk("mem_read_idle", mem.mem_read, 0);
            chk("mem_write_idle", mem.mem_write, 0);
        end
        chk("resp_valid", core.resp_valid, resp_pending);
        if (resp_pending) begin
            chk("resp_rdata", core.resp_rdata, exp_rdata);
            chk("resp_we", core.resp_we, exp_we);
            chk("resp_err", core.resp_err, exp_err);
        end else begin
            chk("resp_err_idle", core.resp_err, 0);
        end
        if (after_reset) begin
            chk("rst_mem_addr", mem.mem_addr, 0);
            chk("rst_mem_wdata", mem.mem_wdata, 0);
            chk("rst_resp_rdata", core.resp_rdata, 0);
            chk("rst_resp_we", core.resp_we, 0);
        end
    endtask

    // Apply inputs, advance one edge, update the model from the rules, check.
    task automatic tick();
        bit push_ok;
        reset           = d_reset;
        core.req_valid  = d_valid;
        core.req_we     = d_we;
        core.req_addr   = d_addr;
        core.req_wdata  = d_wdata;
        core.resp_ready = d_resp_ready;
        mem.mem_finish  = d_finish;
        mem.mem_rdata   = d_rdata;
        @(posedge clock);
        after_reset = !d_reset;
        if (!d_reset) begin
            mq.delete();
            have_cur     = 0;
            resp_pending = 0;
        end else begin
            push_ok = d_valid && (mq.size() < DEPTH);
            if (resp_pending) begin
                if (d_resp_ready) begin
                    resp_pending = 0;
                    $display("txn addr=%h we=%0b rdata=%h err=%0b", resp_addr, exp_we, exp_rdata, exp_err);
                end
            end else if (have_cur) begin
                cur_cycles++;
                if (d_finish || cur_cycles == TMO) begin
                    have_cur     = 0;
                    resp_pending = 1;
                    resp_addr    = cur.addr;
                    exp_we       = cur.we;
                    exp_err      = !d_finish;
                    exp_rdata    = (d_finish && !cur.we) ? d_rdata : 8'h00;
                end
            end else if (mq.size() > 0) begin
                cur        = mq.pop_front();
                have_cur   = 1;
                cur_cycles = 0;
                issued_addr.push_back(cur.addr);
            end
            if (push_ok) mq.push_back('{we: d_we, addr: d_addr, wdata: d_wdata});
        end
        @(negedge clock);
        compare();
    endtask

    task automatic push_one(input logic we, input logic [11:0] addr, input logic [7:0] wdata);
        d_valid = 1; d_we = we; d_addr = addr; d_wdata = wdata;
        tick();
        d_valid = 0;
    endtask

    task automatic drain();
        d_valid = 0; d_finish = 1; d_resp_ready = 1;
        for (int i = 0; i < 400 && (busy || core.resp_valid); i++) tick();
        d_finish = 0;
        chk("drain_idle", busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int          base, mv_cnt, hit;
        bit          rdy, accepted;
        logic [11:0] exp_seq [4];
        int          fin_pct;

        d_reset = 0; d_valid = 1; d_we = 0; d_addr = 12'h305; d_wdata = 8'h00;
        d_resp_ready = 1; d_finish = 0; d_rdata = 8'h00;

        // reset held with a request presented: nothing enters the FIFO
        repeat (3) tick();
        chk("rst_ready", core.req_ready, 1);
        chk("rst_busy", busy, 0);

        // load 0x305, finish on the third BUSY cycle
        d_reset = 1;
        tick();
        d_valid = 0;
        tick();
        tick(); tick();
        d_finish = 1; d_rdata = 8'hA5;
        tick();
        d_finish = 0;
        chk("load_rdata", core.resp_rdata, 8'hA5);
        chk("load_val_drop", mem.mem_val, 0);
        tick();

        // store 0x1FF/0x3C, finish on the first BUSY cycle
        push_one(1'b1, 12'h1FF, 8'h3C);
        tick();
        chk("store_wdata", mem.mem_wdata, 8'h3C);
        d_finish = 1; d_rdata = 8'h77;
        tick();
        d_finish = 0;
        chk("store_3cyc_valid", core.resp_valid, 1);
        chk("store_rdata_zero", core.resp_rdata, 0);
        chk("store_we", core.resp_we, 1);
        tick();

        // back-to-back requests against a depth-2 FIFO
        base = issued_addr.size();
        exp_seq[0] = 12'h100; exp_seq[1] = 12'h200; exp_seq[2] = 12'h300; exp_seq[3] = 12'h400;
        d_valid = 1; d_we = 0;
        for (int i = 0; i < 3; i++) begin
            d_addr = exp_seq[i]; d_wdata = 8'(i);
            tick();
        end
        chk("fifo_full_ready", core.req_ready, 0);
        d_addr = 12'h400; d_finish = 1; accepted = 0;
        for (int i = 0; i < 10; i++) begin
            rdy = core.req_ready;
            tick();
            d_finish = 0;
            if (rdy) begin accepted = 1; break; end
        end
        d_valid = 0;
        chk("fourth_accepted", accepted, 1);
        tick();
        d_finish = 1;
        tick();
        d_finish = 0; d_resp_ready = 0;
        repeat (5) begin
            tick();
            chk("hold_valid", core.resp_valid, 1);
            chk("hold_no_issue", mem.mem_val, 0);
        end
        drain();
        chk("seq_len", issued_addr.size(), base + 4);
        if (issued_addr.size() >= base + 4)
            for (int i = 0; i < 4; i++) chk("issue_order", issued_addr[base + i], exp_seq[i]);

        // timeout: never finish
        push_one(1'b0, 12'h7AB, 8'h00);
        mv_cnt = 0; hit = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (mem.mem_val) mv_cnt++;
            if (core.resp_valid) begin hit = 1; break; end
        end
        chk("timeout_seen", hit, 1);
        chk("timeout_cycles", mv_cnt, TMO);
        chk("timeout_err", core.resp_err, 1);
        chk("timeout_rdata", core.resp_rdata, 0);
        tick();
        push_one(1'b0, 12'h042, 8'h00);
        tick();
        d_finish = 1; d_rdata = 8'h5A;
        tick();
        d_finish = 0;
        chk("after_tmo_rdata", core.resp_rdata, 8'h5A);
        tick();

        // reset in the second BUSY cycle, then a spurious finish while idle
        push_one(1'b0, 12'h2AA, 8'h00);
        push_one(1'b1, 12'h2BB, 8'h11);
        tick();
        d_reset = 0;
        tick();
        d_reset = 1;
        chk("rst_busy_val", mem.mem_val, 0);
        chk("rst_busy_fifo", busy, 0);
        d_finish = 1; d_rdata = 8'hFF;
        tick();
        d_finish = 0;
        chk("spurious_no_resp", core.resp_valid, 0);
        chk("spurious_rdata", core.resp_rdata, 0);
        tick();
        chk("spurious_idle", busy, 0);

        // randomized traffic, with slow-finish phases to provoke timeouts
        for (int i = 0; i < 2500; i++) begin
            fin_pct      = ((i / 500) % 2 == 1) ? 2 : 30;
            d_reset      = ($urandom_range(0, 399) != 0);
            d_valid      = ($urandom_range(0, 1) == 1);
            d_we         = ($urandom_range(0, 1) == 1);
            d_addr       = 12'($urandom);
            d_wdata      = 8'($urandom);
            d_resp_ready = ($urandom_range(0, 99) < 70);
            d_finish     = ($urandom_range(0, 99) < fin_pct);
            d_rdata      = 8'($urandom);
            tick();
        end
        d_reset = 1;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
